// File: rtl/data_memory_sync_if.sv
// Request/response bundle between the MEM pipeline stage (master) and
// data_memory_sync (slave). in_byte_en exists only when DMEM_BYTE_WRITE_EN
// is defined.
interface data_memory_sync_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ctrl_read;
  logic              in_ctrl_write;
  logic [31:0]       in_addr;
  logic [DATA_W-1:0] in_data;
`ifdef DMEM_BYTE_WRITE_EN
  logic [DATA_W/8-1:0] in_byte_en;
`endif
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_err;
  logic              out_init_done;

`ifdef DMEM_BYTE_WRITE_EN
  modport master (
    output in_valid, in_ctrl_read, in_ctrl_write, in_addr, in_data, in_byte_en,
    input  out_ready, out_data, out_valid, out_err, out_init_done
  );
  modport slave (
    input  in_valid, in_ctrl_read, in_ctrl_write, in_addr, in_data, in_byte_en,
    output out_ready, out_data, out_valid, out_err, out_init_done
  );
`else
  modport master (
    output in_valid, in_ctrl_read, in_ctrl_write, in_addr, in_data,
    input  out_ready, out_data, out_valid, out_err, out_init_done
  );
  modport slave (
    input  in_valid, in_ctrl_read, in_ctrl_write, in_addr, in_data,
    output out_ready, out_data, out_valid, out_err, out_init_done
  );
`endif
endinterface

// File: rtl/data_memory_sync.sv
// data_memory_sync: single-port word-addressed RAM with valid/ready request
// handshake, one-cycle registered read, out-of-range error flag and a
// post-reset init sweep (mem[i] = i, or zero when INIT_PATTERN = 0).
// Optional feature macro: DMEM_BYTE_WRITE_EN (per-byte write enables).
module data_memory_sync #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 16,
  parameter int INIT_PATTERN = 1
) (
  input  logic               clk,
  input  logic               rst,
  data_memory_sync_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_err;

  logic              w_ready;
  logic              w_accept;
  logic              w_oor;
  logic [ADDR_W-1:0] w_idx;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_init_word;
  logic              w_do_write;

  assign w_ready  = (r_state == ST_READY);
  assign w_accept = bus.in_valid && w_ready;

  // Address decode, old word and write-merge; the merged word also feeds the
  // write-first read path.
  always_comb begin
    w_oor       = |bus.in_addr[31:ADDR_W];
    w_idx       = bus.in_addr[ADDR_W-1:0];
    w_old       = r_mem[w_idx];
`ifdef DMEM_BYTE_WRITE_EN
    w_merged    = w_old;
    for (int b = 0; b < DATA_W/8; b++)
      if (bus.in_byte_en[b]) w_merged[8*b +: 8] = bus.in_data[8*b +: 8];
`else
    w_merged    = bus.in_data;
`endif
    w_init_word = (INIT_PATTERN != 0) ? DATA_W'(r_init_idx) : '0;
    w_do_write  = w_accept && bus.in_ctrl_write && !w_oor;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: leave INIT once the last entry is being written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_init_idx == '1) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Sweep index, one entry per cycle while initialising.
  always_ff @(posedge clk) begin
    if (rst)                    r_init_idx <= '0;
    else if (r_state == ST_INIT) r_init_idx <= r_init_idx + 1'b1;
  end

  // Array writes: sweep pattern during INIT, accepted in-range writes after.
  // Reset blocks any write at that edge, including a pending request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_INIT) r_mem[r_init_idx] <= w_init_word;
      else if (w_do_write)    r_mem[w_idx]      <= w_merged;
    end
  end

  // Response register: reads and any out-of-range access pulse out_valid;
  // out_data only changes on a read so it holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_out_valid <= w_accept && (bus.in_ctrl_read || (bus.in_ctrl_write && w_oor));
      r_out_err   <= w_accept && w_oor && (bus.in_ctrl_read || bus.in_ctrl_write);
      if (w_accept && bus.in_ctrl_read)
        r_out_data <= w_oor ? '0 : (bus.in_ctrl_write ? w_merged : w_old);
    end
  end

  assign bus.out_ready     = w_ready;
  assign bus.out_init_done = w_ready;
  assign bus.out_data      = r_out_data;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_err       = r_out_err;
endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync (ADDR_W=4, DATA_W=32, INIT_PATTERN=1): directed
// test-plan steps followed by random traffic, checked against an array model.
module tb_data_memory_sync;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_sync_if #(.DATA_W(DW)) bus ();

  data_memory_sync #(.DATA_W(DW), .ADDR_W(AW), .INIT_PATTERN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = i;
    last_data = 32'h0;
  endtask

  // One request cycle, then compare the response with the model.
  task automatic do_req(input logic v, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input string tag);
    logic        oor;
    logic [3:0]  idx;
    logic [31:0] nw;
    logic [31:0] exp_d;
    logic        exp_v;
    logic        exp_e;
    bus.in_valid      = v;
    bus.in_ctrl_read  = rd;
    bus.in_ctrl_write = wr;
    bus.in_addr       = a;
    bus.in_data       = d;
`ifdef DMEM_BYTE_WRITE_EN
    bus.in_byte_en    = be;
`endif
    @(posedge clk); #1;
    oor   = (a >> AW) != 0;
    idx   = a[3:0];
    exp_v = 1'b0;
    exp_e = 1'b0;
    exp_d = last_data;
    if (v) begin
      if (wr && !oor) begin
`ifdef DMEM_BYTE_WRITE_EN
        nw = ref_mem[idx];
        for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
`else
        nw = d ^ {28'h0, be & 4'h0};
`endif
        ref_mem[idx] = nw;
      end
      if (rd) exp_d = oor ? 32'h0 : ref_mem[idx];
      exp_v = rd || (wr && oor);
      exp_e = exp_v && oor;
    end
    chk({tag, ".valid"}, {31'h0, bus.out_valid}, {31'h0, exp_v});
    chk({tag, ".err"},   {31'h0, bus.out_err},   {31'h0, exp_e});
    if (!(exp_v && !rd)) chk({tag, ".data"}, bus.out_data, exp_d);
    last_data = exp_d;
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.in_ctrl_read  = 1'b0;
    bus.in_ctrl_write = 1'b0;
  endtask

  // One reset edge with a live request that must be dropped.
  task automatic do_reset(input string tag);
    rst               = 1'b1;
    bus.in_valid      = 1'b1;
    bus.in_ctrl_read  = 1'b1;
    bus.in_ctrl_write = 1'b1;
    bus.in_addr       = 32'h1;
    bus.in_data       = 32'h5555_5555;
    @(posedge clk); #1;
    chk({tag, ".rst_ready"}, {31'h0, bus.out_ready},     32'h0);
    chk({tag, ".rst_done"},  {31'h0, bus.out_init_done}, 32'h0);
    chk({tag, ".rst_valid"}, {31'h0, bus.out_valid},     32'h0);
    chk({tag, ".rst_err"},   {31'h0, bus.out_err},       32'h0);
    chk({tag, ".rst_data"},  bus.out_data,               32'h0);
    rst = 1'b0;
    model_reset();
  endtask

  // Count init cycles with a read held on the port; it must never be served.
  task automatic wait_ready(input string tag, input int max_cyc, input int expect_n);
    int n;
    n = 0;
    bus.in_valid      = 1'b1;
    bus.in_ctrl_read  = 1'b1;
    bus.in_ctrl_write = 1'b0;
    bus.in_addr       = 32'h0;
    while (!bus.out_ready && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
      if (!bus.out_ready)
        chk({tag, ".init_novalid"}, {31'h0, bus.out_valid}, 32'h0);
    end
    idle();
    chk({tag, ".init_cycles"}, n, expect_n);
    if (expect_n == DEPTH)
      chk({tag, ".init_done"}, {31'h0, bus.out_init_done}, 32'h1);
  endtask

  initial begin
    logic [31:0] a;
    logic        v, rd, wr;
    idle();
    bus.in_addr = 32'h0;
    bus.in_data = 32'h0;
`ifdef DMEM_BYTE_WRITE_EN
    bus.in_byte_en = 4'hF;
`endif
    model_reset();
    @(posedge clk); #1;

    // Init sweep then first read.
    do_reset("init");
    wait_ready("init", 100, DEPTH);
    do_req(1, 1, 0, 32'h5, 32'h0, 4'hF, "rd5");
    chk("rd5.const", bus.out_data, 32'h0000_0005);

    // Write then read, back to back.
    do_req(1, 0, 1, 32'h3, 32'hDEADBEEF, 4'hF, "wr3");
    do_req(1, 1, 0, 32'h3, 32'h0, 4'hF, "rd3");
    chk("rd3.const", bus.out_data, 32'hDEADBEEF);
    do_req(1, 1, 0, 32'h4, 32'h0, 4'hF, "rd4");
    chk("rd4.const", bus.out_data, 32'h0000_0004);
    do_req(0, 0, 0, 32'h0, 32'h0, 4'hF, "hold");

    // Same-cycle read+write is write-first.
    do_req(1, 1, 1, 32'h7, 32'h12345678, 4'hF, "rw7");
    chk("rw7.const", bus.out_data, 32'h12345678);
    do_req(1, 1, 0, 32'h7, 32'h0, 4'hF, "rd7");
    chk("rd7.const", bus.out_data, 32'h12345678);

    // Out of range.
    do_req(1, 0, 1, 32'h10, 32'hFFFFFFFF, 4'hF, "oorwr");
    do_req(1, 1, 0, 32'h0, 32'h0, 4'hF, "rd0");
    chk("rd0.const", bus.out_data, 32'h0);
    do_req(1, 1, 0, 32'h10, 32'h0, 4'hF, "oorrd");
    chk("oorrd.const", {bus.out_err, bus.out_data[30:0]}, 32'h8000_0000);
    do_req(1, 1, 0, 32'h8000_0002, 32'h0, 4'hF, "oorhi");
    do_req(1, 0, 0, 32'h20, 32'h0, 4'hF, "nop_oor");

    // Byte enables.
    do_req(1, 0, 1, 32'h2, 32'hAABBCCDD, 4'b0101, "bewr");
    do_req(1, 1, 0, 32'h2, 32'h0, 4'hF, "berd");
`ifdef DMEM_BYTE_WRITE_EN
    chk("be.const", bus.out_data, 32'h00BB00DD);
`else
    chk("be.const", bus.out_data, 32'hAABBCCDD);
`endif

    // Reset in READY re-initialises contents.
    do_req(1, 0, 1, 32'h9, 32'hCAFEF00D, 4'hF, "wr9");
    do_reset("rst2");
    wait_ready("rst2", 100, DEPTH);
    do_req(1, 1, 0, 32'h9, 32'h0, 4'hF, "rd9");
    chk("rd9.const", bus.out_data, 32'h0000_0009);

    // Reset at init cycle 8 restarts the count.
    do_reset("rst3");
    wait_ready("rst3_part", 8, 8);
    do_reset("rst4");
    wait_ready("rst4", 100, DEPTH);

    // Random traffic, no bubbles between accepted requests.
    for (int k = 0; k < 400; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      rd = $urandom_range(0, 1) != 0;
      wr = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a[31:4] == 28'h0) a[4] = 1'b1;
      end else begin
        a = $urandom_range(0, DEPTH - 1);
      end
      do_req(v, rd, wr, a, $urandom, 4'($urandom), "rand");
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
